// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame FSM state encodings and the default word width.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // A bit index needs at least one bit, even for a 1-bit word.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift/count datapath of the UART transmitter: holds the word being sent
// and tracks which data bit is currently on the line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  input  logic                  count_en,
  output logic                  ser_bit,
  output logic                  done
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;

  // shreg[0] is always the next data bit to be presented on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (count_en) begin
      bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end

  assign done    = count_en && (bit_cnt == LAST_IDX);
  assign ser_bit = shreg[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a parallel word when idle and sends
// start, data (LSB first), optional parity and stop bits, one per CLK.
//
//   state  | meaning
//   IDLE   | line high, waiting for Data_Valid
//   START  | start bit (0) on the line
//   DATA   | data bit bit_cnt on the line
//   PARITY | parity bit on the line
//   STOP   | stop bit (1) on the line
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  uart_state_e state, next_state;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  accept;
  logic                  ser_bit;
  logic                  ser_done;
  logic                  shift_en;
  logic                  count_en;
  logic                  parity_bit;
  logic                  tx_next;
  logic                  busy_next;

  assign shift_en   = (next_state == DATA);
  assign count_en   = (state == DATA);
  assign parity_bit = (^data_q) ^ par_typ_q;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (accept),
    .load_data(P_DATA),
    .shift_en (shift_en),
    .count_en (count_en),
    .ser_bit  (ser_bit),
    .done     (ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are decoded from the next state so the registered line value
  // always matches the state the FSM is in during that cycle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          accept     = 1'b1;
          next_state = START;
        end
      end
      START:   next_state = DATA;
      DATA: begin
        if (ser_done) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY:  next_state = STOP;
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    case (next_state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = ser_bit;
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase
    busy_next = (next_state != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      TX_OUT <= tx_next;
      busy   <= busy_next;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

endmodule
